// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 6-to-3 group mux: alternates sel between two 3-bit groups every
// DWELL cycles and swaps in a buffered group pair only at frame boundaries.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [2:0] grp0_in,
    input  logic [2:0] grp1_in,
    output logic [2:0] grp0_q,
    output logic [2:0] grp1_q,
    output logic       sel,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, SHOW0, SHOW1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       pend_full;
    logic [2:0] pend0, pend1;
    logic       dwell_end, frame_end, commit, xfer;

    assign load_ready = !pend_full;
    assign dwell_end  = (cnt == CNT_LAST);
    assign frame_end  = (state == SHOW1) && dwell_end;
    // Active groups only change in IDLE or as a frame ends, so the mux never shows a torn frame.
    assign commit     = (state == IDLE) || frame_end;
    assign xfer       = load_valid && !pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 1'b0;
            frame_done <= 1'b0;
            pend_full  <= 1'b0;
            pend0      <= '0;
            pend1      <= '0;
            grp0_q     <= '0;
            grp1_q     <= '0;
        end else begin
            frame_done <= frame_end;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    sel <= 1'b0;
                    if (en) state <= SHOW0;
                end
                SHOW0: begin
                    if (dwell_end) begin
                        state <= SHOW1;
                        cnt   <= '0;
                        sel   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHOW1: begin
                    if (dwell_end) begin
                        state <= en ? SHOW0 : IDLE;
                        cnt   <= '0;
                        sel   <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    sel   <= 1'b0;
                end
            endcase

            if (commit && pend_full) begin
                grp0_q    <= pend0;
                grp1_q    <= pend1;
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend0     <= grp0_in;
                pend1     <= grp1_in;
                pend_full <= 1'b1;
            end
        end
    end
endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Time-multiplexing controller placed directly upstream of the 6-to-3 group multiplexer. It holds two 3-bit groups (group 0 = A,B,C; group 1 = D,E,F), drives the multiplexer's `sel` so each group is presented for a programmable number of cycles, and accepts new group pairs through a valid/ready handshake. New data is committed only at frame boundaries, so the multiplexer output never shows a half-updated frame.

## Interface
Parameters:
- `DWELL`, default 4: number of cycles each group is selected. Legal range is 1..255.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  scan enable, sampled at frame boundaries and in IDLE.
- `load_valid`  in  1  a new group pair is offered on `grp0_in` / `grp1_in`.
- `load_ready`  out  1  the pending buffer is empty and can accept a pair.
- `grp0_in`  in  3  new group 0; bit2 = A, bit1 = B, bit0 = C.
- `grp1_in`  in  3  new group 1; bit2 = D, bit1 = E, bit0 = F.
- `grp0_q`  out  3  active group 0; drives the multiplexer's A, B, C inputs.
- `grp1_q`  out  3  active group 1; drives the multiplexer's D, E, F inputs.
- `sel`  out  1  multiplexer select; 0 selects group 0, 1 selects group 1.
- `frame_done`  out  1  one-cycle pulse after each completed frame.

## Operation
Storage:
- Active registers drive `grp0_q` and `grp1_q`.
- A one-entry pending buffer holds the next pair, with a `pend_full` flag.
- An 8-bit dwell counter `cnt` tracks cycles within a group.

States:
- IDLE, SHOW0 and SHOW1.
- `sel` is a registered output equal to 1 only in SHOW1, so it is glitch-free.

Transitions:
- IDLE -> SHOW0 when `en` = 1.
- SHOW0 -> SHOW1 when `cnt` = DWELL-1.
- SHOW1 -> SHOW0 when `cnt` = DWELL-1 and `en` = 1.
- SHOW1 -> IDLE when `cnt` = DWELL-1 and `en` = 0.
- In all other cycles the state holds.

Counter:
- Increments each cycle in SHOW0 and SHOW1.
- Cleared to 0 on every state change.
- Held at 0 in IDLE.

Handshake:
- `load_ready` = !`pend_full`, combinational from the flag.
- A transfer occurs on an edge where `load_valid` && `load_ready`: the pair is written to the pending buffer and `pend_full` is set.
- While `pend_full` = 1, no transfer is possible.

Commit:
- A commit point is any edge in IDLE, or the edge leaving SHOW1.
- At a commit point with `pend_full` = 1, the pending pair is copied to the active registers and `pend_full` is cleared.
- A transfer and a commit never coincide, because a transfer requires `pend_full` = 0 and a commit requires `pend_full` = 1.

Enable and frames:
- Deasserting `en` mid-frame does not truncate the frame. The current SHOW0/SHOW1 sequence completes, then the block enters IDLE with `sel` = 0.
- `frame_done` is registered: it is 1 for the single cycle after the edge leaving SHOW1, whether the next state is SHOW0 or IDLE.

Reset (async, `rst_n` = 0), all at once:
- State = IDLE, `cnt` = 0, `pend_full` = 0.
- `grp0_q` = 0, `grp1_q` = 0, `sel` = 0, `frame_done` = 0.
- `load_ready` = 1.
- Reset mid-frame aborts immediately; a pending pair is discarded.

## Timing
- Frame period is 2·DWELL cycles: `sel` = 0 for DWELL cycles, then `sel` = 1 for DWELL cycles.
- With DWELL = 1, `sel` toggles every cycle while enabled.
- Start latency: if `en` is sampled at 1 in IDLE at edge t, the block is in SHOW0 from t+1 and `sel` rises at t+1+DWELL.
- Load latency in IDLE: a pair accepted at edge t appears on `grp0_q` / `grp1_q` after edge t+1.
- Load latency while scanning: the pair appears after the edge leaving SHOW1, i.e. at most 2·DWELL cycles after acceptance.
- `load_ready` returns to 1 in the cycle after a commit.
- `frame_done` rises one cycle after the last SHOW1 cycle and coincides with the first cycle of the next SHOW0, or of IDLE.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-scan with `pend_full` = 1 -> all outputs are 0 and `load_ready` = 1 immediately, without waiting for a clock edge. After release the block is in IDLE.
- **Basic scan (DWELL = 4):** load grp0 = 3'b101 and grp1 = 3'b010 in IDLE, then `en` = 1 -> outputs update one edge after the load. `sel` shows the pattern 0000 1111 repeating; `frame_done` pulses every 8 cycles.
- **Deferred load:** with DWELL = 4, offer pair 3'b111 / 3'b001 during SHOW0 cycle 1 -> it is accepted and `load_ready` drops. `grp*_q` hold the old values until the edge leaving SHOW1, then show the new values, and `load_ready` returns to 1.
- **Backpressure:** offer a second pair while `pend_full` = 1, holding `load_valid` = 1 -> no transfer until `load_ready` = 1. The second pair then commits at the following frame end, and the first pair is shown for exactly one full frame.
- **Enable drop:** drop `en` during SHOW0 -> SHOW0 and SHOW1 still complete (8 cycles at DWELL = 4), then one `frame_done` pulse, then IDLE with `sel` = 0 and `cnt` held at 0.
- **DWELL = 1:** `sel` alternates 0,1,0,1 and `frame_done` pulses every 2 cycles. A load accepted in SHOW0 commits at the very next SHOW1 exit.
